ssd1963_bus_seq: RTL and testbench

Timed 8080-style bus sequencer between an Avalon-MM slave port and the SSD1963 LCD controller's 8-bit parallel interface. Each CPU access stalls on waitrequest while the block generates a properly timed bus cycle (setup / strobe / hold) with correct D/C selection. A built-in fill engine streams a 24-bit RGB888 pixel N times as back-to-back data bytes, so the CPU does not have to copy pixels for rectangle clears.

---
 rtl/ssd1963_bus_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_ssd1963_bus_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1963_bus_seq.sv
// Avalon-MM slave to SSD1963 8080-style 8-bit bus sequencer with timed setup/strobe/hold
// cycles and a built-in RGB888 fill engine for back-to-back pixel streaming.
module ssd1963_bus_seq #(
    parameter int unsigned WR_LOW  = 2,
    parameter int unsigned WR_HIGH = 2,
    parameter int unsigned RD_LOW  = 8,
    parameter int unsigned RD_HIGH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avalon_slave_address,
    input  logic        avalon_slave_chipselect,
    input  logic        avalon_slave_write,
    input  logic        avalon_slave_read,
    input  logic [31:0] avalon_slave_writedata,
    output logic [31:0] avalon_slave_readdata,
    output logic        avalon_slave_waitrequest,
    output logic        cs_n,
    output logic        dc_n,
    output logic        wr_n,
    output logic        rd_n,
    inout  wire  [7:0]  d
);

    localparam logic [3:0] WrLowCyc  = (WR_LOW  == 0) ? 4'd1 : 4'(WR_LOW);
    localparam logic [3:0] WrHighCyc = (WR_HIGH == 0) ? 4'd1 : 4'(WR_HIGH);
    localparam logic [3:0] RdLowCyc  = (RD_LOW  == 0) ? 4'd1 : 4'(RD_LOW);
    localparam logic [3:0] RdHighCyc = (RD_HIGH == 0) ? 4'd1 : 4'(RD_HIGH);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  timer_q, timer_d;
    logic        op_write_q, op_write_d;
    logic        op_dc_q, op_dc_d;
    logic        op_fill_q, op_fill_d;
    logic [7:0]  op_byte_q, op_byte_d;
    logic [7:0]  rdbyte_q, rdbyte_d;
    logic [31:0] readdata_q, readdata_d;
    logic        busy_q, busy_d;
    logic [23:0] fill_cnt_q, fill_cnt_d;
    logic [23:0] pattern_q, pattern_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        abort_q, abort_d;
    logic        reg_ack_q, reg_ack_d;

    logic request, reg_req, bus_active, last_of_pixel;
    logic unused_wdata;

    assign unused_wdata = ^avalon_slave_writedata[30:24];

    assign request = avalon_slave_chipselect & (avalon_slave_read | avalon_slave_write);
    // STATUS/COUNT is serviced outside the byte FSM so it stays reachable during a fill.
    assign reg_req = request & (avalon_slave_address == 2'd3);

    function automatic logic [7:0] pix_byte(input logic [23:0] pat, input logic [1:0] idx);
        case (idx)
            2'd0:    pix_byte = pat[23:16];
            2'd1:    pix_byte = pat[15:8];
            default: pix_byte = pat[7:0];
        endcase
    endfunction

    assign last_of_pixel = (byte_idx_q == 2'd2);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        op_write_d = op_write_q;
        op_dc_d    = op_dc_q;
        op_fill_d  = op_fill_q;
        op_byte_d  = op_byte_q;
        rdbyte_d   = rdbyte_q;
        readdata_d = readdata_q;
        busy_d     = busy_q;
        fill_cnt_d = fill_cnt_q;
        pattern_d  = pattern_q;
        byte_idx_d = byte_idx_q;
        abort_d    = abort_q;
        reg_ack_d  = 1'b0;

        if (reg_req && !reg_ack_q) begin
            reg_ack_d = 1'b1;
            if (avalon_slave_write) begin
                if (!busy_q) begin
                    fill_cnt_d = avalon_slave_writedata[23:0];
                end else if (avalon_slave_writedata[31]) begin
                    abort_d = 1'b1;
                end
            end else begin
                readdata_d = {busy_q, 7'b0, fill_cnt_q};
            end
        end

        case (state_q)
            StIdle: begin
                if (busy_q) begin
                    if (abort_q) begin
                        busy_d     = 1'b0;
                        fill_cnt_d = '0;
                        abort_d    = 1'b0;
                        byte_idx_d = '0;
                    end else begin
                        op_write_d = 1'b1;
                        op_dc_d    = 1'b1;
                        op_fill_d  = 1'b1;
                        op_byte_d  = pix_byte(pattern_q, byte_idx_q);
                        state_d    = StSetup;
                    end
                end else if (request && avalon_slave_address != 2'd3) begin
                    op_fill_d = 1'b0;
                    if (avalon_slave_write) begin
                        op_write_d = 1'b1;
                        op_byte_d  = avalon_slave_writedata[7:0];
                        case (avalon_slave_address)
                            2'd0: begin
                                op_dc_d = 1'b0;
                                state_d = StSetup;
                            end
                            2'd1: begin
                                op_dc_d = 1'b1;
                                state_d = StSetup;
                            end
                            default: begin
                                pattern_d  = avalon_slave_writedata[23:0];
                                busy_d     = (fill_cnt_q != '0);
                                byte_idx_d = '0;
                                state_d    = StDone;
                            end
                        endcase
                    end else if (avalon_slave_address == 2'd1) begin
                        op_write_d = 1'b0;
                        op_dc_d    = 1'b1;
                        state_d    = StSetup;
                    end else begin
                        readdata_d = '0;
                        state_d    = StDone;
                    end
                end
            end
            StSetup: begin
                timer_d = op_write_q ? (WrLowCyc - 4'd1) : (RdLowCyc - 4'd1);
                state_d = StStrobe;
            end
            StStrobe: begin
                if (timer_q == '0) begin
                    if (!op_write_q) begin
                        rdbyte_d = d;
                    end
                    timer_d = op_write_q ? (WrHighCyc - 4'd1) : (RdHighCyc - 4'd1);
                    state_d = StHold;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            StHold: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 4'd1;
                end else if (op_fill_q) begin
                    if (abort_q || (last_of_pixel && fill_cnt_q == 24'd1)) begin
                        busy_d     = 1'b0;
                        fill_cnt_d = '0;
                        abort_d    = 1'b0;
                        byte_idx_d = '0;
                        op_fill_d  = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        // Straight back to SETUP keeps cs_n low with no gap between bytes.
                        if (last_of_pixel) begin
                            fill_cnt_d = fill_cnt_q - 24'd1;
                            byte_idx_d = '0;
                            op_byte_d  = pix_byte(pattern_q, 2'd0);
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            op_byte_d  = pix_byte(pattern_q, byte_idx_q + 2'd1);
                        end
                        state_d = StSetup;
                    end
                end else begin
                    if (!op_write_q) begin
                        readdata_d = {24'b0, rdbyte_q};
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            op_write_q <= 1'b0;
            op_dc_q    <= 1'b1;
            op_fill_q  <= 1'b0;
            op_byte_q  <= '0;
            rdbyte_q   <= '0;
            readdata_q <= '0;
            busy_q     <= 1'b0;
            fill_cnt_q <= '0;
            pattern_q  <= '0;
            byte_idx_q <= '0;
            abort_q    <= 1'b0;
            reg_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            op_write_q <= op_write_d;
            op_dc_q    <= op_dc_d;
            op_fill_q  <= op_fill_d;
            op_byte_q  <= op_byte_d;
            rdbyte_q   <= rdbyte_d;
            readdata_q <= readdata_d;
            busy_q     <= busy_d;
            fill_cnt_q <= fill_cnt_d;
            pattern_q  <= pattern_d;
            byte_idx_q <= byte_idx_d;
            abort_q    <= abort_d;
            reg_ack_q  <= reg_ack_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset releases the bus at once.
    assign bus_active = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);

    assign cs_n = ~bus_active;
    assign dc_n = bus_active ? op_dc_q : 1'b1;
    assign wr_n = ~((state_q == StStrobe) && op_write_q);
    assign rd_n = ~((state_q == StStrobe) && !op_write_q);
    assign d    = (bus_active && op_write_q) ? op_byte_q : {8{1'bz}};

    assign avalon_slave_readdata    = readdata_q;
    assign avalon_slave_waitrequest = request & ~((state_q == StDone) | reg_ack_q);

endmodule

// File: tb/tb_ssd1963_bus_seq.sv
// Scoreboard bench for ssd1963_bus_seq: stimulus queues expected bus bytes and read data,
// a negedge monitor pops and compares as the DUT presents them.
module tb_ssd1963_bus_seq;

    localparam int WL = 2;
    localparam int WH = 2;
    localparam int RL = 8;
    localparam int RH = 4;
    localparam int WrLat   = 2 + WL + WH;
    localparam int RdLat   = 2 + RL + RH;
    localparam int FillByt = 1 + WL + WH;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        cs_n, dc_n, wr_n, rd_n;
    tri   [7:0]  d;
    logic [7:0]  lcd_val;

    assign d = (!rd_n) ? lcd_val : 8'bz;

    ssd1963_bus_seq #(
        .WR_LOW (WL),
        .WR_HIGH(WH),
        .RD_LOW (RL),
        .RD_HIGH(RH)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .avalon_slave_address    (address),
        .avalon_slave_chipselect (chipselect),
        .avalon_slave_write      (write),
        .avalon_slave_read       (read),
        .avalon_slave_writedata  (writedata),
        .avalon_slave_readdata   (readdata),
        .avalon_slave_waitrequest(waitrequest),
        .cs_n                    (cs_n),
        .dc_n                    (dc_n),
        .wr_n                    (wr_n),
        .rd_n                    (rd_n),
        .d                       (d)
    );

    typedef struct {
        logic [31:0] val;
        logic [31:0] mask;
    } rd_exp_t;

    logic [8:0] exp_bytes[$];
    rd_exp_t    exp_rd[$];
    int checks = 0;
    int passes = 0;
    int bytes_seen = 0;
    int last_cs_run = 0;
    int cs_run = 0;
    int wr_w = 0;
    int rd_w = 0;
    logic prev_wr = 1'b1;
    logic prev_rd = 1'b1;
    int model_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic access(input logic [1:0] addr, input logic is_wr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdat);
        @(posedge clk);
        #1;
        address    = addr;
        chipselect = 1'b1;
        write      = is_wr;
        read       = !is_wr;
        writedata  = wd;
        lat        = 0;
        rdat       = '0;
        forever begin
            @(negedge clk);
            if (!waitrequest) begin
                rdat = readdata;
                break;
            end
            lat++;
            if (lat > 20000) begin
                checks++;
                $display("FAIL access_timeout: addr %0d still stalled after %0d cycles", addr, lat);
                break;
            end
        end
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
    endtask

    task automatic push_fill(input logic [23:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            exp_bytes.push_back({1'b1, pat[23:16]});
            exp_bytes.push_back({1'b1, pat[15:8]});
            exp_bytes.push_back({1'b1, pat[7:0]});
        end
    endtask

    task automatic push_rd(input logic [31:0] val, input logic [31:0] mask);
        rd_exp_t e;
        e.val  = val;
        e.mask = mask;
        exp_rd.push_back(e);
    endtask

    // Monitor: bus bytes, strobe widths, chip-select runs and Avalon read completions.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_wr = 1'b1;
            prev_rd = 1'b1;
            wr_w    = 0;
            rd_w    = 0;
            cs_run  = 0;
        end else begin
            if (!cs_n) cs_run++;
            else if (cs_run != 0) begin
                last_cs_run = cs_run;
                cs_run      = 0;
            end
            if (!wr_n) begin
                if (prev_wr) begin
                    bytes_seen++;
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_byte: got dc_n=%b d=0x%02h required none",
                                 dc_n, d);
                    end else begin
                        logic [8:0] e;
                        e = exp_bytes.pop_front();
                        check("wr_byte", {23'b0, dc_n, d}, {23'b0, e});
                    end
                    check("cs_n_during_strobe", {31'b0, cs_n}, 32'd0);
                end
                wr_w++;
            end else if (!prev_wr) begin
                check("wr_low_width", wr_w, WL);
                wr_w = 0;
            end
            if (!rd_n) begin
                if (prev_rd) check("rd_bus_value", {24'b0, d}, {24'b0, lcd_val});
                rd_w++;
            end else if (!prev_rd) begin
                check("rd_low_width", rd_w, RL);
                rd_w = 0;
            end
            prev_wr = wr_n;
            prev_rd = rd_n;
            if (chipselect && read && !write && !waitrequest) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_read: got 0x%08h required none", readdata);
                end else begin
                    rd_exp_t e;
                    e = exp_rd.pop_front();
                    check("readdata", readdata & e.mask, e.val & e.mask);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          base;
        int          n;
        logic [31:0] r1, r2, rdat;
        logic [7:0]  b;
        logic [23:0] pat;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = '0;
        writedata  = '0;
        lcd_val    = '0;
        #1;
        check("reset_outputs", {28'b0, cs_n, dc_n, wr_n, rd_n}, 32'hF);
        check("reset_readdata", readdata, 32'h0);
        #20;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Command write 0x2C.
        exp_bytes.push_back({1'b0, 8'h2C});
        access(2'd0, 1'b1, 32'h0000_002C, lat, rdat);
        check("cmd_latency", lat, WrLat);
        check("cmd_cs_low_cycles", last_cs_run, 1 + WL + WH);
        check("cs_n_after_cmd", {31'b0, cs_n}, 32'd1);

        // Data read from the panel.
        lcd_val = 8'hA5;
        push_rd(32'h0000_00A5, 32'hFFFF_FFFF);
        access(2'd1, 1'b0, 32'h0, lat, rdat);
        check("rd_latency", lat, RdLat);

        // Two-pixel fill.
        access(2'd3, 1'b1, 32'd2, lat, rdat);
        check("count_latency", lat, 1);
        push_fill(24'h112233, 2);
        access(2'd2, 1'b1, 32'h0011_2233, lat, rdat);
        check("fill_ack_latency", lat, 1);
        repeat (2 * 3 * FillByt + 8) @(posedge clk);
        check("fill_cs_low_run", last_cs_run, 6 * FillByt);
        check("fill_bytes_drained", exp_bytes.size(), 0);
        push_rd(32'h0, 32'hFFFF_FFFF);
        access(2'd3, 1'b0, 32'h0, lat, rdat);

        // Zero-count fill does nothing.
        access(2'd3, 1'b1, 32'd0, lat, rdat);
        base = bytes_seen;
        access(2'd2, 1'b1, 32'h00AB_CDEF, lat, rdat);
        repeat (20) @(posedge clk);
        check("zero_fill_no_strobes", bytes_seen - base, 0);
        push_rd(32'h0, 32'hFFFF_FFFF);
        access(2'd3, 1'b0, 32'h0, lat, rdat);

        // Randomised traffic against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    b = 8'($urandom);
                    n = $urandom_range(0, 1);
                    exp_bytes.push_back({n[0], b});
                    access(n[0] ? 2'd1 : 2'd0, 1'b1, {24'($urandom), b}, lat, rdat);
                    check("rand_wr_latency", lat, WrLat);
                end
                2: begin
                    lcd_val = 8'($urandom);
                    push_rd({24'b0, lcd_val}, 32'hFFFF_FFFF);
                    access(2'd1, 1'b0, 32'h0, lat, rdat);
                    check("rand_rd_latency", lat, RdLat);
                end
                3: begin
                    model_cnt = $urandom_range(0, 3);
                    access(2'd3, 1'b1, 32'(model_cnt), lat, rdat);
                end
                4: begin
                    pat = 24'($urandom);
                    push_fill(pat, model_cnt);
                    access(2'd2, 1'b1, {8'h00, pat}, lat, rdat);
                    check("rand_fill_ack", lat, 1);
                    repeat (model_cnt * 3 * FillByt + 8) @(posedge clk);
                    model_cnt = 0;
                end
                default: begin
                    push_rd(32'(model_cnt), 32'hFFFF_FFFF);
                    access(2'd3, 1'b0, 32'h0, lat, rdat);
                end
            endcase
        end
        check("rand_bytes_drained", exp_bytes.size(), 0);

        // Long fill with status polling and a command queued behind it.
        access(2'd3, 1'b1, 32'd1000, lat, rdat);
        pat = 24'($urandom);
        push_fill(pat, 1000);
        access(2'd2, 1'b1, {8'h00, pat}, lat, rdat);
        repeat (50) @(posedge clk);
        push_rd(32'h8000_0000, 32'hFF00_0000);
        access(2'd3, 1'b0, 32'h0, lat, r1);
        repeat (100) @(posedge clk);
        push_rd(32'h8000_0000, 32'hFF00_0000);
        access(2'd3, 1'b0, 32'h0, lat, r2);
        check("status_cnt_in_range", {31'b0, r1[23:0] < 24'd1000}, 32'd1);
        check("status_cnt_decreasing", {31'b0, r2[23:0] < r1[23:0]}, 32'd1);
        exp_bytes.push_back({1'b0, 8'h2A});
        access(2'd0, 1'b1, 32'h0000_002A, lat, rdat);
        check("cmd_stalled_by_fill", {31'b0, lat > 10000}, 32'd1);
        check("long_fill_drained", exp_bytes.size(), 0);
        push_rd(32'h0, 32'hFFFF_FFFF);
        access(2'd3, 1'b0, 32'h0, lat, rdat);

        // Abort during the fifth byte of a five-pixel fill.
        access(2'd3, 1'b1, 32'd5, lat, rdat);
        push_fill(24'hABCDEF, 5);
        base = bytes_seen;
        access(2'd2, 1'b1, 32'h00AB_CDEF, lat, rdat);
        n = 0;
        while (bytes_seen - base < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        access(2'd3, 1'b1, 32'h8000_0000, lat, rdat);
        repeat (20) @(posedge clk);
        check("abort_bytes_emitted", bytes_seen - base, 5);
        check("abort_bytes_left", exp_bytes.size(), 10);
        exp_bytes.delete();
        push_rd(32'h0, 32'hFFFF_FFFF);
        access(2'd3, 1'b0, 32'h0, lat, rdat);

        // Reset pulsed mid-strobe.
        access(2'd3, 1'b1, 32'd7, lat, rdat);
        exp_bytes.push_back({1'b0, 8'h5A});
        @(posedge clk);
        #1;
        address    = 2'd0;
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = 32'h5A;
        n = 0;
        while (wr_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_strobe_outputs", {28'b0, cs_n, dc_n, wr_n, rd_n}, 32'hF);
        check("rst_mid_strobe_readdata", readdata, 32'h0);
        chipselect = 1'b0;
        write      = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_rd(32'h0, 32'hFFFF_FFFF);
        access(2'd3, 1'b0, 32'h0, lat, rdat);
        check("post_reset_no_bytes_pending", exp_bytes.size(), 0);

        repeat (5) @(posedge clk);
        check("reads_drained", exp_rd.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
